// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_F = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_ERR    = 2'd3
    } arb_state_e;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT_CYC  = 64;

    function automatic logic is_busy(input arb_state_e s);
        return (s == ST_BUSY_F) || (s == ST_BUSY_D);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Cycle counter that flags a downstream access that has run TIMEOUT_CYC cycles without completing.
module arb_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] count_r;

    // Count busy cycles; cleared whenever no access is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {TW{1'b0}};
        end else if (clear) begin
            count_r <= {TW{1'b0}};
        end else if (enable) begin
            count_r <= count_r + TW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto one shared mem_system port, data first with a fetch starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] f_Addr,
    input  logic        f_Rd,
    output logic [15:0] f_DataOut,
    output logic        f_Done,
    output logic        f_Stall,
    input  logic [15:0] d_Addr,
    input  logic [15:0] d_DataIn,
    input  logic        d_Rd,
    input  logic        d_Wr,
    output logic [15:0] d_DataOut,
    output logic        d_Done,
    output logic        d_Stall,
    output logic [15:0] mem_Addr,
    output logic [15:0] mem_DataIn,
    output logic        mem_Rd,
    output logic        mem_Wr,
    input  logic [15:0] mem_DataOut,
    input  logic        mem_Done,
    input  logic        mem_err,
    output logic        err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e    state_r;
    logic [15:0]   addr_r;
    logic [15:0]   data_r;
    logic          rd_r;
    logic          wr_r;
    logic [SW-1:0] streak_r;

    logic f_pend_s;
    logic d_pend_s;
    logic busy_s;
    logic done_ok_s;
    logic wd_expired_s;

    assign f_pend_s  = f_Rd;
    assign d_pend_s  = d_Rd | d_Wr;
    assign busy_s    = is_busy(state_r);
    assign done_ok_s = busy_s & mem_Done & ~mem_err;

    arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (~busy_s),
        .enable  (busy_s),
        .expired (wd_expired_s)
    );

    // Grant FSM: latches the winning request and tracks the data-side streak while fetch waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            addr_r   <= 16'h0000;
            data_r   <= 16'h0000;
            rd_r     <= 1'b0;
            wr_r     <= 1'b0;
            streak_r <= {SW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mem_err || (d_Rd && d_Wr)) begin
                        state_r <= ST_ERR;
                    end else if (d_pend_s && (!f_pend_s || (streak_r < SW'(STARVE_LIMIT)))) begin
                        state_r <= ST_BUSY_D;
                        addr_r  <= d_Addr;
                        data_r  <= d_DataIn;
                        rd_r    <= d_Rd;
                        wr_r    <= d_Wr;
                        if (f_pend_s) begin
                            streak_r <= (streak_r == SW'(STARVE_LIMIT)) ? streak_r : streak_r + SW'(1);
                        end else begin
                            streak_r <= {SW{1'b0}};
                        end
                    end else if (f_pend_s) begin
                        state_r  <= ST_BUSY_F;
                        addr_r   <= f_Addr;
                        data_r   <= 16'h0000;
                        rd_r     <= 1'b1;
                        wr_r     <= 1'b0;
                        streak_r <= {SW{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY_F, ST_BUSY_D: begin
                    if (mem_err) begin
                        state_r <= ST_ERR;
                    end else if (mem_Done) begin
                        state_r <= ST_IDLE;
                    end else if (wd_expired_s) begin
                        state_r <= ST_ERR;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_ERR: begin
                    state_r <= ST_ERR;
                end
                default: begin
                    state_r <= ST_ERR;
                end
            endcase
        end
    end

    // Downstream drive and completion routing back to the owner of the current access.
    always_comb begin
        mem_Addr   = busy_s ? addr_r : 16'h0000;
        mem_DataIn = busy_s ? data_r : 16'h0000;
        mem_Rd     = busy_s & rd_r;
        mem_Wr     = busy_s & wr_r;
        f_Done     = done_ok_s & (state_r == ST_BUSY_F);
        d_Done     = done_ok_s & (state_r == ST_BUSY_D);
        f_DataOut  = f_Done ? mem_DataOut : 16'h0000;
        d_DataOut  = d_Done ? mem_DataOut : 16'h0000;
        err        = (state_r == ST_ERR);
        if (state_r == ST_ERR) begin
            f_Stall = 1'b1;
            d_Stall = 1'b1;
        end else begin
            f_Stall = f_pend_s & ~f_Done;
            d_Stall = d_pend_s & ~d_Done;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single fetch, priority, starvation guard, timeout, errors, reset abort.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] f_Addr;
    logic        f_Rd;
    logic [15:0] f_DataOut;
    logic        f_Done;
    logic        f_Stall;
    logic [15:0] d_Addr;
    logic [15:0] d_DataIn;
    logic        d_Rd;
    logic        d_Wr;
    logic [15:0] d_DataOut;
    logic        d_Done;
    logic        d_Stall;
    logic [15:0] mem_Addr;
    logic [15:0] mem_DataIn;
    logic        mem_Rd;
    logic        mem_Wr;
    logic [15:0] mem_DataOut;
    logic        mem_Done;
    logic        mem_err;
    logic        err;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .STARVE_LIMIT (4),
        .TIMEOUT_CYC  (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .f_Addr      (f_Addr),
        .f_Rd        (f_Rd),
        .f_DataOut   (f_DataOut),
        .f_Done      (f_Done),
        .f_Stall     (f_Stall),
        .d_Addr      (d_Addr),
        .d_DataIn    (d_DataIn),
        .d_Rd        (d_Rd),
        .d_Wr        (d_Wr),
        .d_DataOut   (d_DataOut),
        .d_Done      (d_Done),
        .d_Stall     (d_Stall),
        .mem_Addr    (mem_Addr),
        .mem_DataIn  (mem_DataIn),
        .mem_Rd      (mem_Rd),
        .mem_Wr      (mem_Wr),
        .mem_DataOut (mem_DataOut),
        .mem_Done    (mem_Done),
        .mem_err     (mem_err),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        f_Addr = 16'h0000; f_Rd = 1'b0;
        d_Addr = 16'h0000; d_DataIn = 16'h0000; d_Rd = 1'b0; d_Wr = 1'b0;
        mem_DataOut = 16'h0000; mem_Done = 1'b0; mem_err = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [15:0] exp_addr [6];

    initial begin
        exp_addr[0] = 16'h0040; exp_addr[1] = 16'h0040; exp_addr[2] = 16'h0040;
        exp_addr[3] = 16'h0040; exp_addr[4] = 16'h0030; exp_addr[5] = 16'h0040;

        do_reset();
        settle();
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_mem_rd", {15'd0, mem_Rd}, 16'd0);
        chk("rst_mem_wr", {15'd0, mem_Wr}, 16'd0);
        chk("rst_f_stall", {15'd0, f_Stall}, 16'd0);
        chk("rst_d_stall", {15'd0, d_Stall}, 16'd0);

        // 1: lone fetch, memory answers on the sixth busy cycle
        f_Rd = 1'b1; f_Addr = 16'h0010;
        settle();
        chk("t1_stall_pending", {15'd0, f_Stall}, 16'd1);
        chk("t1_no_issue_yet", {15'd0, mem_Rd}, 16'd0);
        tick();
        chk("t1_mem_rd_c1", {15'd0, mem_Rd}, 16'd1);
        chk("t1_mem_addr", mem_Addr, 16'h0010);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("t1_mem_rd_hold", {15'd0, mem_Rd}, 16'd1);
            chk("t1_no_done", {15'd0, f_Done}, 16'd0);
            chk("t1_stall_hold", {15'd0, f_Stall}, 16'd1);
        end
        tick();
        mem_Done = 1'b1; mem_DataOut = 16'hBEEF;
        settle();
        chk("t1_f_done", {15'd0, f_Done}, 16'd1);
        chk("t1_f_data", f_DataOut, 16'hBEEF);
        chk("t1_f_stall_low", {15'd0, f_Stall}, 16'd0);
        chk("t1_d_done_quiet", {15'd0, d_Done}, 16'd0);
        tick();
        clear_inputs();
        settle();
        chk("t1_idle_after", {15'd0, mem_Rd}, 16'd0);

        // 2: simultaneous fetch and data write, data wins
        f_Rd = 1'b1; f_Addr = 16'h0020;
        d_Wr = 1'b1; d_Addr = 16'h0200; d_DataIn = 16'h1234;
        tick();
        chk("t2_mem_wr", {15'd0, mem_Wr}, 16'd1);
        chk("t2_mem_rd", {15'd0, mem_Rd}, 16'd0);
        chk("t2_mem_addr", mem_Addr, 16'h0200);
        chk("t2_mem_datain", mem_DataIn, 16'h1234);
        chk("t2_f_stalled", {15'd0, f_Stall}, 16'd1);
        mem_Done = 1'b1;
        settle();
        chk("t2_d_done", {15'd0, d_Done}, 16'd1);
        chk("t2_f_not_done", {15'd0, f_Done}, 16'd0);
        chk("t2_d_stall_low", {15'd0, d_Stall}, 16'd0);
        tick();
        d_Wr = 1'b0; mem_Done = 1'b0;
        settle();
        chk("t2_gap_idle", {15'd0, mem_Rd | mem_Wr}, 16'd0);
        chk("t2_f_still_stalled", {15'd0, f_Stall}, 16'd1);
        tick();
        chk("t2_fetch_issue", {15'd0, mem_Rd}, 16'd1);
        chk("t2_fetch_addr", mem_Addr, 16'h0020);
        mem_Done = 1'b1; mem_DataOut = 16'h5555;
        settle();
        chk("t2_f_data", f_DataOut, 16'h5555);
        tick();
        clear_inputs();
        settle();

        // 3: continuous data reads starve fetch until the guard trips
        f_Rd = 1'b1; f_Addr = 16'h0030;
        d_Rd = 1'b1; d_Addr = 16'h0040;
        for (int g = 0; g < 6; g++) begin
            tick();
            chk("t3_grant_addr", mem_Addr, exp_addr[g]);
            mem_Done = 1'b1; mem_DataOut = 16'h00A0 + 16'(g);
            settle();
            chk("t3_done_side", {15'd0, f_Done}, (exp_addr[g] == 16'h0030) ? 16'd1 : 16'd0);
            tick();
            mem_Done = 1'b0;
        end
        clear_inputs();
        settle();

        // 4: memory never completes; watchdog trips on the 64th busy cycle
        do_reset();
        f_Rd = 1'b1; f_Addr = 16'h0050;
        tick();
        chk("t4_busy0", {15'd0, mem_Rd}, 16'd1);
        for (int c = 1; c <= 63; c++) begin
            tick();
        end
        chk("t4_busy63_rd", {15'd0, mem_Rd}, 16'd1);
        chk("t4_busy63_no_err", {15'd0, err}, 16'd0);
        tick();
        chk("t4_err_set", {15'd0, err}, 16'd1);
        chk("t4_err_mem_rd", {15'd0, mem_Rd}, 16'd0);
        chk("t4_err_f_stall", {15'd0, f_Stall}, 16'd1);
        chk("t4_err_d_stall", {15'd0, d_Stall}, 16'd1);
        f_Rd = 1'b0;
        tick();
        tick();
        chk("t4_err_sticky", {15'd0, err}, 16'd1);
        chk("t4_stall_sticky", {15'd0, f_Stall}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_clears_err", {15'd0, err}, 16'd0);
        chk("t4_rst_idle", {15'd0, mem_Rd}, 16'd0);

        // 5a: read and write together is a protocol error
        d_Rd = 1'b1; d_Wr = 1'b1; d_Addr = 16'h0100;
        tick();
        chk("t5a_err", {15'd0, err}, 16'd1);
        chk("t5a_no_access", {15'd0, mem_Rd | mem_Wr}, 16'd0);
        do_reset();

        // 5b: mem_err during a fetch access
        f_Rd = 1'b1; f_Addr = 16'h0060;
        tick();
        chk("t5b_busy", {15'd0, mem_Rd}, 16'd1);
        tick();
        mem_err = 1'b1;
        settle();
        chk("t5b_no_done_on_err", {15'd0, f_Done}, 16'd0);
        tick();
        mem_err = 1'b0; mem_Done = 1'b1; mem_DataOut = 16'h7777;
        settle();
        chk("t5b_err", {15'd0, err}, 16'd1);
        chk("t5b_err_blocks_done", {15'd0, f_Done}, 16'd0);
        chk("t5b_err_blocks_data", f_DataOut, 16'h0000);
        do_reset();

        // 6: reset in the middle of a data access
        d_Rd = 1'b1; d_Addr = 16'h0070;
        tick();
        chk("t6_busy_d", {15'd0, mem_Rd}, 16'd1);
        chk("t6_busy_addr", mem_Addr, 16'h0070);
        d_Rd = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; mem_Done = 1'b1;
        settle();
        chk("t6_aborted", {15'd0, mem_Rd}, 16'd0);
        chk("t6_no_d_done", {15'd0, d_Done}, 16'd0);
        mem_Done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t6_no_reissue", {15'd0, mem_Rd | mem_Wr}, 16'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
